// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction fetch block: FSM encodings, reset PC and fetch-entry layout.
package ifetch_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = INSTR_W + PC_W;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Register-based FIFO of fetched {instr, pc}; head is visible the edge after push.
// Push while full is accepted only alongside a pop; flush clears pointers and count but not storage.
module fetch_queue
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_dat_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [ENTRY_W-1:0] head_dat_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               do_push;
    logic               do_pop;

    assign full_o     = (cnt_q == CNT_W'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign head_dat_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Owns the PC and fetch FSM, reads the async ROM and feeds decode through valid/ready; first instr 2 edges after IDLE.
// Fetch stalls when the queue is full and not popping; redirect flushes and reloads the PC, halt stops fetching.
module instr_fetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [1:0]  state
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [31:0]        pc_q;
    logic [31:0]        pc_d;
    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic               pop;
    logic               fetch;
    logic               q_full;
    logic               q_empty;
    logic [CNT_W-1:0]   q_count;
    logic [ENTRY_W-1:0] head_dat;
    fetch_entry_t       head_e;
    fetch_entry_t       push_e;
    logic               unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign imem_addr = pc_q;
    assign state     = state_q;

    assign out_valid = (q_count != '0);
    assign head_e    = fetch_entry_t'(head_dat);
    assign out_instr = head_e.instr;
    assign out_pc    = head_e.pc;

    assign pop   = !q_empty && out_ready;
    assign fetch = (state_q == ST_RUN) && !halt && !redirect_valid && (!q_full || pop);

    assign push_e.instr = imem_rd;
    assign push_e.pc    = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Halt is a level: it holds HALTED and is re-evaluated every cycle, including leaving IDLE.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = halt ? ST_HALTED : ST_RUN;
            ST_RUN:    state_d = halt ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = halt ? ST_HALTED : ST_RUN;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= ST_IDLE;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (fetch),
        .push_dat_i (push_e),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .head_dat_o (head_dat),
        .full_o     (q_full),
        .empty_o    (q_empty),
        .count_o    (q_count)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed scenarios for instr_fetch_ctrl; expected fetch PCs are queued and a monitor checks each handshake.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign imem_rd = imem_addr ^ XOR_PAT;

    instr_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2),
        .PC_STEP  (32'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .state          (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(first + 32'(4 * i));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs until every queued expectation has been consumed, counting cycles without out_valid.
    task automatic wait_drain(input int budget, output int bubbles);
        int n;
        n = 0;
        bubbles = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
            if (exp_q.size() != 0 && out_valid !== 1'b1) bubbles++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got pc %h expected no transfer", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("pop_pc", out_pc, e);
                check("pop_instr", out_instr, e ^ XOR_PAT);
            end
        end
    end

    initial begin
        int bub;
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        cyc();
        cyc();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // Streaming from reset: first valid on the second edge after release, then no bubbles
        rst_n = 1'b1;
        push_exp(32'h0, 8);
        cyc();
        check("lat_valid_e1", 32'(out_valid), 32'd0);
        check("lat_state_e1", 32'(state), 32'd1);
        cyc();
        check("lat_valid_e2", 32'(out_valid), 32'd1);
        check("lat_pc_e2", out_pc, 32'h0);
        wait_drain(40, bub);
        check("stream_bubbles", 32'(bub), 32'd0);
        out_ready = 1'b0;

        // Stall: queue fills to 2, head held, address frozen at 8
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_pc", out_pc, 32'h0);
        check("stall_instr", out_instr, 32'h0 ^ XOR_PAT);
        check("stall_addr", imem_addr, 32'h8);
        push_exp(32'h0, 4);
        out_ready = 1'b1;
        wait_drain(40, bub);
        out_ready = 1'b0;

        // Redirect while the queue holds two entries
        cyc();
        cyc();
        check("pre_redir_addr", imem_addr, 32'h18);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_addr", imem_addr, 32'h100);
        push_exp(32'h100, 2);
        out_ready = 1'b1;
        wait_drain(40, bub);
        out_ready = 1'b0;

        // Halt mid-run: drain, address held, resume without skipping
        cyc();
        cyc();
        check("pre_halt_addr", imem_addr, 32'h110);
        halt      = 1'b1;
        out_ready = 1'b1;
        push_exp(32'h108, 2);
        cyc();
        check("halt_state", 32'(state), 32'd2);
        cyc();
        check("halt_drained", 32'(out_valid), 32'd0);
        cyc();
        cyc();
        check("halt_addr", imem_addr, 32'h110);
        check("halt_state_hold", 32'(state), 32'd2);
        halt = 1'b0;
        push_exp(32'h110, 3);
        cyc();
        check("resume_state", 32'(state), 32'd1);
        wait_drain(40, bub);
        out_ready = 1'b0;

        // Redirect near the top of the address space: PC wraps to 0
        cyc();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        cyc();
        redirect_valid = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        out_ready = 1'b1;
        wait_drain(40, bub);
        out_ready = 1'b0;

        // Reset and redirect in the same cycle: reset wins
        cyc();
        cyc();
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        cyc();
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        check("rr_valid", 32'(out_valid), 32'd0);
        check("rr_addr", imem_addr, 32'h0);
        check("rr_state", 32'(state), 32'd0);
        push_exp(32'h0, 2);
        out_ready = 1'b1;
        wait_drain(40, bub);
        out_ready = 1'b0;
        cyc();
        cyc();
        check("final_exp_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
